// File: rtl/mem_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mem_arb_pkg                                                   |
// | Brief    : Shared types and default constants for the memory port        |
// |            arbiter (state encoding, widths, watchdog sizing helper).     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package mem_arb_pkg;

   localparam int unsigned c_ADDR_W_DEF  = 32;
   localparam int unsigned c_DATA_W_DEF  = 32;
   localparam int unsigned c_TIMEOUT_DEF = 64;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DATA  = 2'd1,
      ST_FETCH = 2'd2
   } arb_state_t;

   // Watchdog counter width; a disabled watchdog still gets a 1-bit vector
   function automatic int unsigned cnt_width(input int unsigned timeout);
      return (timeout > 0) ? $clog2(timeout + 1) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arb_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mem_arb_timer                                                 |
// | Brief    : Watchdog counter. Cleared when an access issues, advances     |
// |            each cycle the access waits for ack, flags expiry on the      |
// |            last allowed waiting cycle. TIMEOUT=0 disables it.            |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module mem_arb_timer
   import mem_arb_pkg::*;
#(
   parameter int unsigned TIMEOUT = c_TIMEOUT_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expire
);

   localparam int unsigned c_CW = cnt_width(TIMEOUT);

   generate
      if (TIMEOUT == 0) begin : g_disabled
         assign o_expire = 1'b0;
      end else begin : g_enabled
         localparam logic [c_CW-1:0] c_LAST = c_CW'(TIMEOUT - 1);

         logic [c_CW-1:0] r_count;

         // Count waiting cycles of the current access; restart on each issue
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               r_count <= '0;
            end else if (i_clr) begin
               r_count <= '0;
            end else if (i_en) begin
               r_count <= r_count + 1'b1;
            end
         end

         // Expiry only matters while still waiting (no ack this cycle)
         assign o_expire = i_en & (r_count == c_LAST);
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mem_port_arbiter                                              |
// | Brief    : Shares one memory port between instruction fetch and the      |
// |            MEM-stage data access. Data wins over fetch, req/ack          |
// |            handshake to memory, pipeline stalls, hung-memory watchdog.   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W  = c_ADDR_W_DEF,
   parameter int unsigned DATA_W  = c_DATA_W_DEF,
   parameter int unsigned TIMEOUT = c_TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              reset,
   // instruction fetch side
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_valid,
   // data access side (EX/MEM register)
   input  logic              dm_rd,
   input  logic              dm_wt,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_valid,
   // pipeline control
   output logic              stall_pipe,
   output logic              stall_if,
   // memory port
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   // status
   output logic              timeout_err
);

   arb_state_t        r_state;
   logic              r_mem_req;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;
   logic [DATA_W-1:0] r_dm_rdata;
   logic [DATA_W-1:0] r_if_rdata;
   logic              r_dm_valid;
   logic              r_if_valid;
   logic              r_timeout_err;
   logic              r_flush;

   logic              w_dm_pend;
   logic              w_if_pend;
   logic              w_issue;
   logic              w_busy;
   logic              w_expire;
   logic              w_fetch_live;

   // A request is pending until its completion pulse; during the pulse the
   // request lines still show the finished op and must not reissue it.
   assign w_dm_pend    = (dm_rd | dm_wt) & ~r_dm_valid;
   assign w_if_pend    = if_req & ~r_if_valid;
   assign w_issue      = (r_state == ST_IDLE) & (w_dm_pend | w_if_pend);
   assign w_busy       = (r_state != ST_IDLE);
   // A fetch that was dropped at any point while outstanding is a flush
   assign w_fetch_live = if_req & ~r_flush;

   mem_arb_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .i_clr    (w_issue),
      .i_en     (w_busy & ~mem_ack),
      .o_expire (w_expire)
   );

   // Arbitration FSM with registered memory-port and completion outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= ST_IDLE;
         r_mem_req     <= 1'b0;
         r_mem_we      <= 1'b0;
         r_mem_addr    <= '0;
         r_mem_wdata   <= '0;
         r_dm_rdata    <= '0;
         r_if_rdata    <= '0;
         r_dm_valid    <= 1'b0;
         r_if_valid    <= 1'b0;
         r_timeout_err <= 1'b0;
         r_flush       <= 1'b0;
      end else begin
         r_dm_valid <= 1'b0;
         r_if_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_dm_pend) begin
                  // read+write together resolves to a write
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= dm_wt;
                  r_mem_addr  <= dm_addr;
                  r_mem_wdata <= dm_wdata;
                  r_state     <= ST_DATA;
               end else if (w_if_pend) begin
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= 1'b0;
                  r_mem_addr  <= if_addr;
                  r_mem_wdata <= '0;
                  r_flush     <= 1'b0;
                  r_state     <= ST_FETCH;
               end
            end
            ST_DATA: begin
               if (mem_ack) begin
                  r_mem_req  <= 1'b0;
                  r_dm_valid <= 1'b1;
                  if (!r_mem_we) begin
                     r_dm_rdata <= mem_rdata;
                  end
                  r_state    <= ST_IDLE;
               end else if (w_expire) begin
                  // abort and release the pipeline with zero data
                  r_mem_req     <= 1'b0;
                  r_timeout_err <= 1'b1;
                  r_dm_valid    <= 1'b1;
                  r_dm_rdata    <= '0;
                  r_state       <= ST_IDLE;
               end
            end
            ST_FETCH: begin
               if (mem_ack) begin
                  r_mem_req <= 1'b0;
                  if (w_fetch_live) begin
                     r_if_valid <= 1'b1;
                     r_if_rdata <= mem_rdata;
                  end
                  r_state   <= ST_IDLE;
               end else if (w_expire) begin
                  r_mem_req     <= 1'b0;
                  r_timeout_err <= 1'b1;
                  if (w_fetch_live) begin
                     r_if_valid <= 1'b1;
                     r_if_rdata <= '0;
                  end
                  r_state       <= ST_IDLE;
               end else if (!if_req) begin
                  r_flush <= 1'b1;
               end
            end
            default: begin
               r_mem_req <= 1'b0;
               r_state   <= ST_IDLE;
            end
         endcase
      end
   end

   assign mem_req     = r_mem_req;
   assign mem_we      = r_mem_we;
   assign mem_addr    = r_mem_addr;
   assign mem_wdata   = r_mem_wdata;
   assign dm_rdata    = r_dm_rdata;
   assign if_rdata    = r_if_rdata;
   assign dm_valid    = r_dm_valid;
   assign if_valid    = r_if_valid;
   assign timeout_err = r_timeout_err;

   assign stall_pipe  = (dm_rd | dm_wt) & ~r_dm_valid;
   assign stall_if    = stall_pipe | (if_req & ~r_if_valid);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_mem_port_arbiter                                           |
// | Brief    : Self-checking bench for mem_port_arbiter: directed scenarios  |
// |            followed by randomized transactions against a transaction-    |
// |            level reference model.                                        |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_mem_port_arbiter;

   localparam int c_TMO = 8;
   localparam int K_RD = 0, K_WT = 1, K_RW = 2, K_IF = 3, K_TIE = 4, K_FL = 5;

   logic        clk;
   logic        reset;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_valid;
   logic        dm_rd;
   logic        dm_wt;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [31:0] dm_rdata;
   logic        dm_valid;
   logic        stall_pipe;
   logic        stall_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic        timeout_err;

   int          n_chk;
   int          n_fail;
   logic [31:0] exp_dm;
   logic [31:0] exp_if;
   logic        exp_terr;

   mem_port_arbiter #(
      .ADDR_W  (32),
      .DATA_W  (32),
      .TIMEOUT (c_TMO)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .if_req      (if_req),
      .if_addr     (if_addr),
      .if_rdata    (if_rdata),
      .if_valid    (if_valid),
      .dm_rd       (dm_rd),
      .dm_wt       (dm_wt),
      .dm_addr     (dm_addr),
      .dm_wdata    (dm_wdata),
      .dm_rdata    (dm_rdata),
      .dm_valid    (dm_valid),
      .stall_pipe  (stall_pipe),
      .stall_if    (stall_if),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .mem_ack     (mem_ack),
      .timeout_err (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop if the sequence ever stalls
   initial begin
      #500000;
      $display("FAIL global_timeout: observed no end of test, required finish");
      $fatal(1, "simulation time limit");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h required %h", tag, obs, exp);
      end
   endtask

   // Memory responder: called just after the issue edge. Acks after `delay`
   // waiting cycles, or the watchdog aborts if the wait reaches c_TMO cycles.
   task automatic serve(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input bit chk_wdata, input int delay, input logic [31:0] rd,
                        input int flush_at, output bit to);
      to = 1'b0;
      chk("issue_req", mem_req, 1);
      chk("issue_we", mem_we, we);
      chk("issue_addr", mem_addr, addr);
      if (chk_wdata) chk("issue_wdata", mem_wdata, wdata);
      for (int c = 0; c < 64; c++) begin
         if (c == flush_at) if_req = 1'b0;
         if (c == delay) begin
            mem_ack   = 1'b1;
            mem_rdata = rd;
            tick();
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            return;
         end
         if (c == c_TMO - 1) begin
            tick();
            to = 1'b1;
            return;
         end
         tick();
         chk("req_hold", mem_req, 1);
         chk("addr_hold", mem_addr, addr);
      end
   endtask

   // One pipeline-level transaction: data op, fetch, both (tie) or flushed fetch
   task automatic do_txn(input int kind, input logic [31:0] da, input logic [31:0] dw,
                         input logic [31:0] fa, input int d1, input logic [31:0] r1,
                         input int d2, input logic [31:0] r2);
      bit hd, hf, fl, wt, to;
      hd = (kind == K_RD) || (kind == K_WT) || (kind == K_RW) || (kind == K_TIE);
      hf = (kind == K_IF) || (kind == K_TIE) || (kind == K_FL);
      fl = (kind == K_FL);
      wt = (kind == K_WT) || (kind == K_RW) || (kind == K_TIE);
      dm_rd    = (kind == K_RD) || (kind == K_RW);
      dm_wt    = wt;
      dm_addr  = da;
      dm_wdata = dw;
      if_req   = hf;
      if_addr  = fa;
      #1;
      chk("stall_pipe_req", stall_pipe, hd);
      chk("stall_if_req", stall_if, hd | hf);
      chk("req_not_yet", mem_req, 0);
      tick();
      if (hd) begin
         serve(wt, da, dw, 1'b1, d1, r1, -1, to);
         if (to) begin
            exp_terr = 1'b1;
            exp_dm   = '0;
         end else if (!wt) begin
            exp_dm = r1;
         end
         chk("dm_valid", dm_valid, 1);
         chk("dm_rdata", dm_rdata, exp_dm);
         chk("dm_req_drop", mem_req, 0);
         chk("dm_terr", timeout_err, exp_terr);
         chk("stall_pipe_valid", stall_pipe, 0);
         chk("if_valid_quiet", if_valid, 0);
         chk("stall_if_valid", stall_if, hf);
         dm_rd = 1'b0;
         dm_wt = 1'b0;
         tick();
         chk("dm_valid_pulse", dm_valid, 0);
         if (!hf) chk("dm_idle_after", mem_req, 0);
      end
      if (hf) begin
         serve(1'b0, fa, '0, 1'b0, d2, r2, fl ? 1 : -1, to);
         if (to) exp_terr = 1'b1;
         if (!fl) exp_if = to ? 32'h0 : r2;
         chk("if_valid", if_valid, !fl);
         chk("if_rdata", if_rdata, exp_if);
         chk("if_req_drop", mem_req, 0);
         chk("if_terr", timeout_err, exp_terr);
         chk("dm_valid_quiet", dm_valid, 0);
         if_req = 1'b0;
         tick();
         chk("if_valid_pulse", if_valid, 0);
         chk("if_idle_after", mem_req, 0);
      end
   endtask

   initial begin
      n_chk     = 0;
      n_fail    = 0;
      exp_dm    = '0;
      exp_if    = '0;
      exp_terr  = 1'b0;
      reset     = 1'b1;
      if_req    = 1'b0;
      if_addr   = '0;
      dm_rd     = 1'b0;
      dm_wt     = 1'b0;
      dm_addr   = '0;
      dm_wdata  = '0;
      mem_rdata = '0;
      mem_ack   = 1'b0;
      #2 reset  = 1'b0;
      tick();
      tick();
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_dm_valid", dm_valid, 0);
      chk("rst_if_valid", if_valid, 0);
      chk("rst_terr", timeout_err, 0);
      chk("rst_stall_if", stall_if, 0);
      reset = 1'b1;
      tick();

      // Load 0x40, ack after 3 waiting cycles
      do_txn(K_RD, 32'h40, 32'h0, 32'h0, 3, 32'hDEADBEEF, 0, 32'h0);
      // Tie: write wins, fetch follows
      do_txn(K_TIE, 32'h80, 32'h12345678, 32'h100, 2, 32'h0BAD0BAD, 2, 32'hCAFEF00D);
      // Flushed fetch
      do_txn(K_FL, 32'h0, 32'h0, 32'h200, 0, 32'h0, 3, 32'hAAAA5555);
      // Ack on the expiry cycle is still a normal completion
      do_txn(K_RD, 32'h48, 32'h0, 32'h0, c_TMO - 1, 32'h13572468, 0, 32'h0);
      // Watchdog: no ack
      do_txn(K_RD, 32'h44, 32'h0, 32'h0, 100, 32'h11111111, 0, 32'h0);
      // Error stays set across a normal write (read+write treated as write)
      do_txn(K_RW, 32'h4C, 32'h0F0F0F0F, 32'h0, 1, 32'h22222222, 0, 32'h0);

      // Reset two cycles into an outstanding write
      dm_wt    = 1'b1;
      dm_addr  = 32'h300;
      dm_wdata = 32'h55;
      tick();
      chk("rstmid_issue", mem_req, 1);
      tick();
      tick();
      reset = 1'b0;
      dm_wt = 1'b0;
      #1;
      chk("rstmid_req", mem_req, 0);
      chk("rstmid_we", mem_we, 0);
      chk("rstmid_addr", mem_addr, 0);
      chk("rstmid_wdata", mem_wdata, 0);
      chk("rstmid_terr", timeout_err, 0);
      chk("rstmid_dm_rdata", dm_rdata, 0);
      chk("rstmid_if_rdata", if_rdata, 0);
      chk("rstmid_stall", stall_pipe, 0);
      exp_terr = 1'b0;
      exp_dm   = '0;
      exp_if   = '0;
      tick();
      reset     = 1'b1;
      mem_ack   = 1'b1;
      mem_rdata = 32'h99999999;
      tick();
      mem_ack = 1'b0;
      chk("stray_dm_valid", dm_valid, 0);
      chk("stray_if_valid", if_valid, 0);
      chk("stray_req", mem_req, 0);
      chk("stray_dm_rdata", dm_rdata, 0);
      tick();

      // Randomized transactions
      for (int i = 0; i < 40; i++) begin
         int k;
         k = $urandom_range(0, 5);
         do_txn(k, $urandom, $urandom, $urandom, $urandom_range(0, 10), $urandom,
                (k == K_FL) ? $urandom_range(2, 10) : $urandom_range(0, 10), $urandom);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
